// File: rtl/seg_scan_driver.sv
// Scan generator for an 8-digit common-anode 7-segment display: walks an active-low
// digit select, decodes the returned digit value and blanks around every digit switch.
module seg_scan_driver #(
  parameter int DIV   = 50000,
  parameter int GUARD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit_data,
  input  logic [7:0] blank_mask,
  input  logic [7:0] dp_mask,
  output logic [7:0] sel,
  output logic [6:0] seg,
  output logic       dp_n,
  output logic       frame_tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  logic          run_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic          frame_q;
  logic [6:0]    seg_dec;
  logic          off;

  // Select depends on registered state only, so the chooser sees a glitch-free code.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sel
      assign sel[gi] = ~(run_q && (idx_q == 3'(gi)));
    end
  endgenerate

  always_comb begin
    seg_dec = 7'h7F;
    case (digit_data)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
      default: seg_dec = 7'h7F;
    endcase
  end

  // The last-cycle term pre-blanks so a new slot never opens with the old digit lit.
  assign off = !en || !run_q || (cnt_q < GUARD_C) || (cnt_q == LAST) || blank_mask[idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      run_q <= en;
      if (!run_q) begin
        cnt_q <= '0;
        idx_q <= '0;
      end else if (cnt_q == LAST) begin
        cnt_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      seg_q   <= off ? 7'h7F : seg_dec;
      dp_q    <= off ? 1'b1 : ~dp_mask[idx_q];
      frame_q <= run_q && (cnt_q == LAST) && (idx_q == 3'd7);
    end
  end

  assign seg        = seg_q;
  assign dp_n       = dp_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboarded bench for seg_scan_driver: a slot-level reference model predicts each
// cycle's outputs into a queue, and a negedge monitor pops and compares them.
module tb_seg_scan_driver;
  localparam int DIV   = 8;
  localparam int GUARD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [3:0] digit_data;
  logic [7:0] blank_mask = 8'h00;
  logic [7:0] dp_mask    = 8'h00;
  logic [7:0] sel;
  logic [6:0] seg;
  logic       dp_n;
  logic       frame_tick;

  seg_scan_driver #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .en(en), .digit_data(digit_data),
    .blank_mask(blank_mask), .dp_mask(dp_mask),
    .sel(sel), .seg(seg), .dp_n(dp_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Digit chooser: returns the stored value of whichever digit sel selects.
  logic [3:0] chooser [8];
  always_comb begin
    digit_data = 4'h0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] oh;
      oh = 8'b1 << i;
      if (sel == ~oh) digit_data = chooser[i];
    end
  end

  typedef struct packed {
    logic [7:0] sel;
    logic [6:0] seg;
    logic       dp_n;
    logic       ft;
  } exp_t;

  exp_t q[$];
  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_pass   = 0;
  int n_cycle  = 0;
  bit active   = 0;

  // Reference model: m_k counts cycles since the display started running.
  bit m_run = 0;
  int m_k   = 0;

  function automatic int m_pos();
    return m_k % DIV;
  endfunction
  function automatic int m_dig();
    return (m_k / DIV) % 8;
  endfunction

  task automatic step();
    exp_t e;
    int   pos, dig;
    bit   off;
    @(posedge clk);
    pos = m_pos();
    dig = m_dig();
    if (rst) begin
      m_run  = 0;
      m_k    = 0;
      e.seg  = 7'h7F;
      e.dp_n = 1'b1;
      e.ft   = 1'b0;
    end else begin
      off    = !en || !m_run || pos < GUARD || pos == DIV - 1 || blank_mask[dig];
      e.seg  = off ? 7'h7F : dec_tab[chooser[dig]];
      e.dp_n = off ? 1'b1 : !dp_mask[dig];
      e.ft   = m_run && pos == DIV - 1 && dig == 7;
      m_k    = m_run ? (m_k + 1) % (8 * DIV) : 0;
      m_run  = en;
    end
    if (m_run) begin
      logic [7:0] oh;
      oh = 8'b1 << m_dig();
      e.sel = ~oh;
    end else begin
      e.sel = 8'hFF;
    end
    q.push_back(e);
    active = 1;
    n_cycle++;
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, n_cycle, act, req);
  endtask

  always @(negedge clk) begin
    if (active) begin
      if (q.size() == 0) begin
        check("queue_underflow", 8'd0, 8'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sel", sel, e.sel);
        check("seg", {1'b0, seg}, {1'b0, e.seg});
        check("dp_n", {7'd0, dp_n}, {7'd0, e.dp_n});
        check("frame_tick", {7'd0, frame_tick}, {7'd0, e.ft});
      end
    end
  end

  initial begin
    int  k;
    bit  found;
    for (int i = 0; i < 8; i++) chooser[i] = 4'(i);

    // Reset held with en high, then free-running scan through several frames.
    rst = 1'b1; en = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (200) step();

    // Blank digit 7, decimal point on digit 2.
    blank_mask = 8'h80; dp_mask = 8'h04;
    repeat (80) step();
    blank_mask = 8'h00; dp_mask = 8'h00;

    // Drop enable mid-slot on digit 5, then restart.
    found = 0;
    for (k = 0; k < 100 && !found; k++) begin
      if (m_run && m_dig() == 5 && m_pos() == 3) found = 1;
      else step();
    end
    check("wait_digit5", {7'd0, found}, 8'd1);
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    repeat (12) step();

    // Reset pulse mid-scan on digit 4.
    found = 0;
    for (k = 0; k < 100 && !found; k++) begin
      if (m_run && m_dig() == 4) found = 1;
      else step();
    end
    check("wait_digit4", {7'd0, found}, 8'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (30) step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) blank_mask = 8'($urandom);
      if ($urandom_range(0, 39) == 0) dp_mask = 8'($urandom);
      if (c % 64 == 0) for (int i = 0; i < 8; i++) chooser[i] = 4'($urandom);
      step();
    end

    @(negedge clk);
    #1;
    active = 0;
    check("queue_drained", 8'(q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
